// File: rtl/demux2_pkg.sv
// Shared widths, lane index type and counter helper for the two-lane demultiplexer.
// Optional build macro DEMUX2_RR_EN selects round-robin lane choice in demux2.
package demux2_pkg;

    localparam int DATA_W = 2;
    localparam int CNT_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_idx_t;

    // Accepted-word counters roll over silently at 2**CNT_W.
    function automatic cnt_t cnt_inc(input cnt_t value);
        return value + cnt_t'(1'b1);
    endfunction

endpackage

// File: rtl/demux2_lane.sv
// One output lane: single-entry word register with valid flag and accept counter.
// Load wins over drain, so a simultaneous drain and load keeps valid high.
module demux2_lane
    import demux2_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  data_t data_in,
    input  logic  ready,
    output data_t data_out,
    output logic  valid,
    output cnt_t  cnt
);

    data_t data_r;
    logic  valid_r;
    cnt_t  cnt_r;

    // Word register, valid flag and counter: load, drain or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= data_t'(2'b00);
            valid_r <= 1'b0;
            cnt_r   <= cnt_t'(4'd0);
        end else if (load) begin
            data_r  <= data_in;
            valid_r <= 1'b1;
            cnt_r   <= cnt_inc(cnt_r);
        end else if (valid_r && ready) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
            cnt_r   <= cnt_r;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
            cnt_r   <= cnt_r;
        end
    end

    assign data_out = data_r;
    assign valid    = valid_r;
    assign cnt      = cnt_r;

endmodule

// File: rtl/demux2.sv
// Two-lane demultiplexer: routes each accepted word to the lane picked by selector,
// or by an internal alternating toggle when built with DEMUX2_RR_EN.
module demux2
    import demux2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              selector,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    input  logic              ready_out0,
    input  logic              ready_out1,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    lane_idx_t lane_s;
    logic      in_ready_s;
    logic      accept_s;
    logic      load0_s;
    logic      load1_s;
    logic      lane0_valid_s;
    logic      lane1_valid_s;

`ifdef DEMUX2_RR_EN
    lane_idx_t toggle_r;
    logic      unused_selector_s;

    assign unused_selector_s = selector;

    // Round-robin toggle flips after every accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_r <= LANE0;
        end else if (accept_s) begin
            toggle_r <= (toggle_r == LANE0) ? LANE1 : LANE0;
        end else begin
            toggle_r <= toggle_r;
        end
    end

    assign lane_s = toggle_r;
`else
    assign lane_s = selector ? LANE1 : LANE0;
`endif

    // Accept only when the active lane is empty or draining this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            case (lane_s)
                LANE0:   in_ready_s = !lane0_valid_s || ready_out0;
                LANE1:   in_ready_s = !lane1_valid_s || ready_out1;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign accept_s = valid_in && in_ready_s;
    assign load0_s  = accept_s && (lane_s == LANE0);
    assign load1_s  = accept_s && (lane_s == LANE1);

    demux2_lane u_lane0 (
        .clk      (clk),
        .reset    (reset),
        .load     (load0_s),
        .data_in  (data_in),
        .ready    (ready_out0),
        .data_out (data_out0),
        .valid    (lane0_valid_s),
        .cnt      (cnt0)
    );

    demux2_lane u_lane1 (
        .clk      (clk),
        .reset    (reset),
        .load     (load1_s),
        .data_in  (data_in),
        .ready    (ready_out1),
        .data_out (data_out1),
        .valid    (lane1_valid_s),
        .cnt      (cnt1)
    );

    assign valid_out0 = lane0_valid_s;
    assign valid_out1 = lane1_valid_s;

endmodule

// File: tb/tb_demux2.sv
// Randomized bench for demux2 with an array-based lane model, per-cycle comparison
// and directed scenarios with hand-computed expectations.
module tb_demux2;

    logic       clk;
    logic       reset;
    logic       selector;
    logic [1:0] data_in;
    logic       valid_in;
    logic       in_ready;
    logic [1:0] data_out0;
    logic [1:0] data_out1;
    logic       valid_out0;
    logic       valid_out1;
    logic       ready_out0;
    logic       ready_out1;
    logic [3:0] cnt0;
    logic [3:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: one held word per lane, kept as plain integers.
    int m_data  [2];
    int m_valid [2];
    int m_cnt   [2];
    int m_tog;

    demux2 dut (
        .clk        (clk),
        .reset      (reset),
        .selector   (selector),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .in_ready   (in_ready),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .ready_out0 (ready_out0),
        .ready_out1 (ready_out1),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_lane();
`ifdef DEMUX2_RR_EN
        return m_tog;
`else
        return int'(selector);
`endif
    endfunction

    function automatic int model_ready();
        int l;
        int rdy [2];
        rdy[0] = int'(ready_out0);
        rdy[1] = int'(ready_out1);
        l = model_lane();
        if (reset) return 0;
        return (m_valid[l] == 0 || rdy[l] == 1) ? 1 : 0;
    endfunction

    // Reference model: accept rule, per-lane load/drain, modulo-16 counters.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_data[i] = 0; m_valid[i] = 0; m_cnt[i] = 0;
            end
            m_tog = 0;
        end else begin
            int l, acc;
            int rdy [2];
            rdy[0] = int'(ready_out0);
            rdy[1] = int'(ready_out1);
            l   = model_lane();
            acc = (valid_in && model_ready() == 1) ? 1 : 0;
            for (int i = 0; i < 2; i++) begin
                if (acc == 1 && i == l) begin
                    m_data[i]  = int'(data_in);
                    m_valid[i] = 1;
                    m_cnt[i]   = (m_cnt[i] + 1) % 16;
                end else if (m_valid[i] == 1 && rdy[i] == 1) begin
                    m_valid[i] = 0;
                end
            end
            if (acc == 1) m_tog = 1 - m_tog;
        end
    end

    // Per-cycle comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        chk("data_out0",  int'(data_out0),  m_data[0]);
        chk("data_out1",  int'(data_out1),  m_data[1]);
        chk("valid_out0", int'(valid_out0), m_valid[0]);
        chk("valid_out1", int'(valid_out1), m_valid[1]);
        chk("cnt0",       int'(cnt0),       m_cnt[0]);
        chk("cnt1",       int'(cnt1),       m_cnt[1]);
        chk("in_ready",   int'(in_ready),   model_ready());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] stream [3];
        reset = 1'b1; selector = 1'b0; data_in = 2'b00; valid_in = 1'b0;
        ready_out0 = 1'b0; ready_out1 = 1'b0;
        tick();
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_valid0",   int'(valid_out0), 0);
        tick();
        reset = 1'b0;

        // Three words into lane0, then async reset mid-cycle.
        selector = 1'b0; valid_in = 1'b1; ready_out0 = 1'b1;
        data_in = 2'b01; tick();
        data_in = 2'b10; tick();
        data_in = 2'b11; tick();
        valid_in = 1'b0; ready_out0 = 1'b0;
        chk("pre_rst_valid0", int'(valid_out0), 1);
        chk("pre_rst_cnt0",   int'(cnt0), 3);
        #2 reset = 1'b1;
        #1;
        chk("async_valid0", int'(valid_out0), 0);
        chk("async_cnt0",   int'(cnt0), 0);
        chk("async_data0",  int'(data_out0), 0);
        chk("async_ready",  int'(in_ready), 0);
        tick();
        reset = 1'b0;

        // Single word 11 to lane0; lane1 untouched.
        selector = 1'b0; data_in = 2'b11; valid_in = 1'b1; ready_out0 = 1'b1;
        tick();
        chk("one_data0",  int'(data_out0), 3);
        chk("one_valid0", int'(valid_out0), 1);
        chk("one_cnt0",   int'(cnt0), 1);
        chk("one_valid1", int'(valid_out1), 0);
        chk("one_cnt1",   int'(cnt1), 0);

        // Back-to-back stream 01,00,10 with no bubble.
        stream[0] = 2'b01; stream[1] = 2'b00; stream[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            data_in = stream[i];
            tick();
            chk("stream_data0",  int'(data_out0), int'(stream[i]));
            chk("stream_valid0", int'(valid_out0), 1);
        end
        chk("stream_cnt0", int'(cnt0), 4);
        valid_in = 1'b0;
        do_reset();

        // Lane1 blocked with 10 held; switching selector to lane0 unblocks.
        selector = 1'b1; data_in = 2'b10; valid_in = 1'b1; ready_out1 = 1'b0; ready_out0 = 1'b0;
        tick();
        data_in = 2'b01;
        #1 chk("blk_in_ready", int'(in_ready), 0);
        tick();
        chk("blk_data1", int'(data_out1), 2);
        chk("blk_cnt1",  int'(cnt1), 1);
        selector = 1'b0;
        #1 chk("unblk_in_ready", int'(in_ready), 1);
        tick();
        chk("unblk_data0",  int'(data_out0), 1);
        chk("unblk_valid0", int'(valid_out0), 1);
        valid_in = 1'b0;
        do_reset();

        // Counter wrap on lane1.
        selector = 1'b1; valid_in = 1'b1; ready_out1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 2'(i);
            tick();
        end
        chk("wrap16_cnt1", int'(cnt1), 0);
        tick();
        chk("wrap17_cnt1", int'(cnt1), 1);
        valid_in = 1'b0;
        do_reset();

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            selector   = 1'($urandom % 2);
            data_in    = 2'($urandom % 4);
            valid_in   = 1'(($urandom % 4) != 0);
            ready_out0 = 1'(($urandom % 3) != 0);
            ready_out1 = 1'(($urandom % 3) != 0);
            reset      = 1'(($urandom % 200) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/demux2.md
DEMUX2 -- requirements
Module: demux2

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have port selector  input  1  lane select for the current input word; 0=lane0, 1=lane1.
REQ-004 SHALL have port data_in  input  2  input word.
REQ-005 SHALL have port valid_in  input  1  data_in is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts data_in this cycle.
REQ-007 SHALL have ports data_out0 / data_out1  output  2  registered lane words.
REQ-008 SHALL have ports valid_out0 / valid_out1  output  1  lane word is valid.
REQ-009 SHALL have ports ready_out0 / ready_out1  input  1  downstream of lane consumes the word.
REQ-010 SHALL have ports cnt0 / cnt1  output  4  accepted-word count per lane.

Function
REQ-011 Each lane SHALL hold a one-entry output register (data, valid) and a 4-bit counter.
REQ-012 Active lane X SHALL be selector (or the internal toggle, REQ-024); in_ready SHALL be combinational: !valid_outX || ready_outX, and 0 while reset is high.
REQ-013 An accept SHALL occur on a rising edge with valid_in && in_ready; data_outX <= data_in, valid_outX <= 1, cntX <= cntX+1.
REQ-014 Latency SHALL be 1 cycle: the accepted word appears on data_outX/valid_outX after the accepting edge.
REQ-015 A drain (valid_outX && ready_outX) without a simultaneous load SHALL clear valid_outX; data_outX SHALL hold its last value.
REQ-016 A drain and a load on the same lane in the same cycle SHALL load the new word with valid_outX staying 1 (full throughput, no bubble).
REQ-017 The non-selected lane SHALL only drain; it SHALL never load or count.
REQ-018 With valid_in=1 and in_ready=0, no state SHALL change for the input; upstream holds data_in.
REQ-019 With valid_in=0, in_ready SHALL still reflect REQ-012; ready_outX with valid_outX=0 SHALL have no effect.
REQ-020 Counters SHALL wrap modulo 16 (15 -> 0) without flag.
REQ-021 selector SHALL be sampled only in cycles with valid_in=1; changes while valid_in=0 SHALL have no effect.

Reset
REQ-022 While reset is high, data_out0/1=2'b00, valid_out0/1=0, cnt0/1=0, in_ready=0, the internal toggle=0, asynchronously and regardless of clk.
REQ-023 Reset asserted mid-transfer SHALL discard held words; the first accept is possible on the first rising edge after reset deasserts.

Configuration
REQ-024 With DEMUX2_RR_EN defined, selector SHALL be ignored and an internal toggle (reset 0) SHALL pick the lane, inverting after each accept; without it, selector SHALL pick the lane and no toggle flop SHALL exist. The port list SHALL be identical in both builds.

Structure
REQ-025 Package demux2_pkg SHALL hold DATA_W=2, CNT_W=4, and a 1-bit lane-index typedef.
REQ-026 Sub-module demux2_lane (output register, valid, counter, load/drain logic) SHALL be instantiated twice; demux2 SHALL hold lane select, in_ready, and the RR toggle.

Verification
REQ-027 Reset is asserted mid-cycle while valid_out0=1, cnt0=3 -> all outputs are 0 immediately, before the next clk edge.
REQ-028 selector=0, data_in=2'b11, valid_in=1, ready_out0=1 for one cycle -> next cycle data_out0=11, valid_out0=1, cnt0=1; lane1 is unchanged.
REQ-029 Lane1 holds 2'b10 with ready_out1=0; valid_in=1, selector=1 -> in_ready=0 and data_out1 stays 10; selector switches to 0 -> in_ready=1 and lane0 loads.
REQ-030 Lane0 gets the stream 01,00,10 on consecutive cycles with ready_out0=1 -> data_out0 shows 01,00,10 on consecutive cycles, valid_out0 is continuously 1, cnt0=3.
REQ-031 16 accepts to lane1 -> cnt1 reads 0; a 17th accept -> cnt1=1.
REQ-032 With DEMUX2_RR_EN, 4 words are sent with selector held 1 and both readies at 1 -> the words land on lanes 0,1,0,1; cnt0=2, cnt1=2.
